micro_ucr_hash_iter: RTL and testbench
======================================

// Module: micro_ucr_hash_iter
// PURPOSE
//  Iterative, parametrised micro-UCR hash engine: 12-byte block + 32-bit nonce -> 24-bit hash.
//  Executes one compression round per clk (area-oriented), with a start/valid handshake and a
//  registered target compare. Sits between the block/nonce source and the nonce-search controller.
// PARAMETERS
//  NUM_ROUNDS  32     rounds per hash; legal 16..255
//  ROUND_SPLIT 17     rounds [0,SPLIT) use K1 and XOR mix; rounds [SPLIT,NUM_ROUNDS) use K2 and OR mix
//  H0/H1/H2    8'h01/8'h89/8'hFE   initial chaining bytes a/b/c
//  K1/K2       8'h99/8'hA1         round constants
// PORTS
//  clk          in   1   single clock, all logic on rising edge
//  reset        in   1   synchronous, active-high
//  start        in   1   request; accepted only when busy=0
//  bloque_bytes in   96  block; byte i = bloque_bytes[i*8+:8]
//  nonce        in   32  start nonce; byte n = nonce[n*8+:8]
//  target       in   24  hit threshold; latched with start
//  busy         out  1   high from the cycle after acceptance until valid
//  valid        out  1   one-cycle pulse: hash/hit/nonce_out are final
//  hash         out  24  {a,b,c} result; held until next valid
//  hit          out  1   registered (hash < target), unsigned; meaningful when valid=1
//  nonce_out    out  32  nonce that produced hash
//  exhausted    out  1   search wrapped without hit (see CONFIGURATION)
// BEHAVIOUR
//  Reset: FSM->IDLE; busy, valid, hit, exhausted = 0; hash = 24'h0; nonce_out = 32'h0. Reset wins
//   over start and aborts any in-flight hash; no valid is produced for an aborted hash.
//  FSM: IDLE -(start)-> RUN -(round==NUM_ROUNDS-1)-> FIN -> IDLE. start while busy: ignored.
//   start in the same cycle as valid: accepted (back-to-back, no bubble besides FIN).
//  Accept cycle: latch block, nonce, target; a,b,c <= H0,H1,H2; round <= 0.
//  Schedule (all 8-bit): W[i]=block byte i (i<12); W[12+n]=nonce byte n (n<4);
//   W[i] = W[i-3] | (W[i-9] ^ W[i-14]) for i>=16 (XOR binds first). Rolling 16-byte window,
//   W generated on the fly; no 32-entry array.
//  Round r: x = (r<SPLIT) ? a^b : a|b;  k = (r<SPLIT) ? K1 : K2;
//   a <= b^c;  b <= {c[3:0],4'h0};  c <= x + k + W[r] (mod 256). All three update together.
//  FIN: hash <= {H0+a, H1+b, H2+c} (each mod 256); hit <= ({H0+a,H1+b,H2+c} < target);
//   nonce_out <= working nonce; valid=1 this cycle's next edge (registered pulse).
//  Latency: valid asserts exactly NUM_ROUNDS+1 cycles after the accept edge (33 at default).
//  Boundaries: target=0 -> hit never; target=24'hFFFFFF -> hit unless hash==24'hFFFFFF;
//   ROUND_SPLIT>=NUM_ROUNDS -> all rounds K1/XOR; ROUND_SPLIT=0 -> all K2/OR.
//  Round counter width $clog2(NUM_ROUNDS); no wrap within a hash.
// CONFIGURATION
//  MICRO_UCR_NONCE_SEARCH_EN defined: after FIN with hit=0, the engine re-enters RUN next cycle
//   with nonce+1 (same block/target), no valid pulse for misses; busy stays high. Terminates
//   with valid on first hit (hit=1, nonce_out=winning nonce) or after testing 32'hFFFFFFFF
//   without hit (valid=1, hit=0, exhausted=1, nonce_out=32'hFFFFFFFF). exhausted clears on accept.
//  Not defined: single-shot per start; exhausted tied 0; nonce never incremented.
// TESTING (golden: bit-exact C/Python model of the equations above)
//  1 reset held 3 cycles mid-RUN -> busy=0, valid never pulses, hash=0, next start works normally.
//  2 block=96'h0, nonce=0, target=24'hFFFFFF, start 1 cycle -> valid at accept+33, hash==model,
//    hit=1 unless model hash==24'hFFFFFF.
//  3 start pulsed again at accept+5 and accept+20 -> ignored; single valid at accept+33.
//  4 back-to-back: start held high with 2 block/nonce sets -> two valids 33 cycles apart, both
//    hashes match model; target=0 -> hit=0 on both.
//  5 params NUM_ROUNDS=16, ROUND_SPLIT=0 -> valid at accept+17, hash matches model (all K2/OR).
//  6 SEARCH_EN: nonce=32'hFFFFFFFE, target=0 -> exactly 2 attempts, valid with exhausted=1,
//    nonce_out=32'hFFFFFFFF; target=24'hFFFFFF -> hit on first nonce, one valid at accept+33.

Source files
------------

// File: rtl/micro_ucr_hash_iter.sv
// Iterative micro-UCR hash: 12-byte block + 32-bit nonce -> 24-bit hash, one round per clock.
// Optional nonce search loop enabled by defining MICRO_UCR_NONCE_SEARCH_EN.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one compression round per cycle, round_q = current round
// S_FIN  | finalise hash/hit; emit valid or (search mode) retry with nonce+1
module micro_ucr_hash_iter #(
    parameter int         NUM_ROUNDS  = 32,
    parameter int         ROUND_SPLIT = 17,
    parameter logic [7:0] H0          = 8'h01,
    parameter logic [7:0] H1          = 8'h89,
    parameter logic [7:0] H2          = 8'hFE,
    parameter logic [7:0] K1          = 8'h99,
    parameter logic [7:0] K2          = 8'hA1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic [95:0] bloque_bytes_i,
    input  logic [31:0] nonce_i,
    input  logic [23:0] target_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [23:0] hash_o,
    output logic        hit_o,
    output logic [31:0] nonce_out_o,
    output logic        exhausted_o
);

    localparam int              RW      = $clog2(NUM_ROUNDS);
    localparam logic [RW-1:0]   LAST    = RW'(NUM_ROUNDS - 1);
    localparam logic [31:0]     SPLIT_U = ROUND_SPLIT;

`ifdef MICRO_UCR_NONCE_SEARCH_EN
    localparam bit SEARCH = 1'b1;
`else
    localparam bit SEARCH = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t            state_q;
    logic [95:0]       blk_q;
    logic [31:0]       nonce_q;
    logic [23:0]       target_q;
    logic [7:0]        a_q, b_q, c_q;
    logic [RW-1:0]     round_q;
    // Rolling schedule window: win_q[j] holds W[round + j]
    logic [15:0][7:0]  win_q;
    logic              busy_q, valid_q, hit_q, exh_q;
    logic [23:0]       hash_q;
    logic [31:0]       nonce_out_q;

    logic [31:0] round_ext;
    logic        first_half;
    logic [7:0]  x_d, k_d, c_d, w_new;
    logic [7:0]  ha, hb, hc;
    logic [23:0] hash_d;
    logic        hit_d;
    logic        done;
    logic        accept;

    assign round_ext  = {{(32-RW){1'b0}}, round_q};
    assign first_half = round_ext < SPLIT_U;
    assign x_d        = first_half ? (a_q ^ b_q) : (a_q | b_q);
    assign k_d        = first_half ? K1 : K2;
    assign c_d        = x_d + k_d + win_q[0];
    assign w_new      = win_q[13] | (win_q[7] ^ win_q[2]);

    assign ha     = H0 + a_q;
    assign hb     = H1 + b_q;
    assign hc     = H2 + c_q;
    assign hash_d = {ha, hb, hc};
    assign hit_d  = hash_d < target_q;

    // A miss only loops back when searching and the nonce space is not yet exhausted
    assign done   = !SEARCH || hit_d || (nonce_q == 32'hFFFF_FFFF);
    assign accept = start_i && ((state_q == S_IDLE) || ((state_q == S_FIN) && done));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            blk_q       <= '0;
            nonce_q     <= '0;
            target_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            round_q     <= '0;
            win_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            hit_q       <= 1'b0;
            exh_q       <= 1'b0;
            hash_q      <= '0;
            nonce_out_q <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                end
                S_RUN: begin
                    a_q     <= b_q ^ c_q;
                    b_q     <= {c_q[3:0], 4'h0};
                    c_q     <= c_d;
                    win_q   <= {w_new, win_q[15:1]};
                    round_q <= round_q + 1'b1;
                    if (round_q == LAST) begin
                        state_q <= S_FIN;
                    end
                end
                S_FIN: begin
                    if (done) begin
                        valid_q     <= 1'b1;
                        hash_q      <= hash_d;
                        hit_q       <= hit_d;
                        nonce_out_q <= nonce_q;
                        exh_q       <= SEARCH && !hit_d;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        nonce_q <= nonce_q + 32'd1;
                        a_q     <= H0;
                        b_q     <= H1;
                        c_q     <= H2;
                        round_q <= '0;
                        win_q   <= {nonce_q + 32'd1, blk_q};
                        state_q <= S_RUN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Accept overrides the FIN return-to-idle for back-to-back operation
            if (accept) begin
                blk_q    <= bloque_bytes_i;
                nonce_q  <= nonce_i;
                target_q <= target_i;
                a_q      <= H0;
                b_q      <= H1;
                c_q      <= H2;
                round_q  <= '0;
                win_q    <= {nonce_i, bloque_bytes_i};
                busy_q   <= 1'b1;
                state_q  <= S_RUN;
                if (state_q == S_IDLE) begin
                    exh_q <= 1'b0;
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign valid_o     = valid_q;
    assign hash_o      = hash_q;
    assign hit_o       = hit_q;
    assign nonce_out_o = nonce_out_q;
    assign exhausted_o = exh_q;

endmodule

// File: tb/tb_micro_ucr_hash_iter.sv
// Scoreboard bench for micro_ucr_hash_iter: default-parameter instance plus a
// NUM_ROUNDS=16 / ROUND_SPLIT=0 instance; search tests run when MICRO_UCR_NONCE_SEARCH_EN is set.
module tb_micro_ucr_hash_iter;

`ifdef MICRO_UCR_NONCE_SEARCH_EN
    localparam bit SEARCH = 1'b1;
`else
    localparam bit SEARCH = 1'b0;
`endif

    typedef struct {
        logic [23:0] hash;
        logic        hit;
        logic [31:0] nonce;
        logic        exh;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [95:0] blk;
    logic [31:0] nonce;
    logic [23:0] target;

    logic        busy0, valid0, hit0, exh0;
    logic [23:0] hash0;
    logic [31:0] nout0;
    logic        busy1, valid1, hit1, exh1;
    logic [23:0] hash1;
    logic [31:0] nout1;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    micro_ucr_hash_iter dut32 (
        .clk_i(clk), .reset_i(reset), .start_i(start0),
        .bloque_bytes_i(blk), .nonce_i(nonce), .target_i(target),
        .busy_o(busy0), .valid_o(valid0), .hash_o(hash0), .hit_o(hit0),
        .nonce_out_o(nout0), .exhausted_o(exh0)
    );

    micro_ucr_hash_iter #(.NUM_ROUNDS(16), .ROUND_SPLIT(0)) dut16 (
        .clk_i(clk), .reset_i(reset), .start_i(start1),
        .bloque_bytes_i(blk), .nonce_i(nonce), .target_i(target),
        .busy_o(busy1), .valid_o(valid1), .hash_o(hash1), .hit_o(hit1),
        .nonce_out_o(nout1), .exhausted_o(exh1)
    );

    // Reference: full W expansion up front, then the round loop.
    function automatic logic [23:0] model(input logic [95:0] b, input logic [31:0] n,
                                          input int nr, input int split);
        logic [7:0] w [0:255];
        logic [7:0] a, bb, c, x, k, na, nb, nc;
        for (int i = 0; i < 12; i++) w[i] = b[i*8 +: 8];
        for (int i = 0; i < 4; i++)  w[12+i] = n[i*8 +: 8];
        for (int i = 16; i < nr; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
        a = 8'h01; bb = 8'h89; c = 8'hFE;
        for (int r = 0; r < nr; r++) begin
            if (r < split) begin x = a ^ bb; k = 8'h99; end
            else           begin x = a | bb; k = 8'hA1; end
            na = bb ^ c;
            nb = {c[3:0], 4'h0};
            nc = x + k + w[r];
            a = na; bb = nb; c = nc;
        end
        na = 8'h01 + a; nb = 8'h89 + bb; nc = 8'hFE + c;
        return {na, nb, nc};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [95:0] b, input logic [31:0] n, input logic [23:0] t,
                                input int nr, input int split, input int c, input logic ex);
        exp_t e;
        e.hash  = model(b, n, nr, split);
        e.hit   = e.hash < t;
        e.nonce = n;
        e.exh   = ex;
        e.cyc   = c;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (valid0) begin
            if (q0.size() == 0) chk("dut32_unexpected_valid", valid0, 0);
            else begin
                e = q0.pop_front();
                chk("dut32_latency", cyc, e.cyc);
                chk("dut32_hash", hash0, e.hash);
                chk("dut32_hit", hit0, e.hit);
                chk("dut32_nonce_out", nout0, e.nonce);
                chk("dut32_exhausted", exh0, e.exh);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (valid1) begin
            if (q1.size() == 0) chk("dut16_unexpected_valid", valid1, 0);
            else begin
                e = q1.pop_front();
                chk("dut16_latency", cyc, e.cyc);
                chk("dut16_hash", hash1, e.hash);
                chk("dut16_hit", hit1, e.hit);
                chk("dut16_nonce_out", nout1, e.nonce);
                chk("dut16_exhausted", exh1, e.exh);
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive one start pulse; returns the cycle index of the accepting edge.
    task automatic issue(input bit which, input logic [95:0] b, input logic [31:0] n,
                         input logic [23:0] t, output int acc);
        @(negedge clk);
        blk = b; nonce = n; target = t;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        logic [95:0] ba, bb2;
        logic [23:0] t4;

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        blk = '0; nonce = '0; target = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", busy0, 0);
        chk("reset_valid", valid0, 0);
        chk("reset_hash", hash0, 0);
        chk("reset_hit", hit0, 0);
        chk("reset_nonce_out", nout0, 0);
        chk("reset_exhausted", exh0, 0);

        // Abort mid-run with a 3-cycle reset; no valid may follow
        issue(0, 96'h1111_2222_3333_4444_5555_6666, 32'h0000_0042, 24'hFFFFFF, acc);
        wait_until(acc + 10);
        chk("run_busy", busy0, 1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_hash", hash0, 0);
        repeat (40) @(negedge clk);
        chk("abort_still_idle", busy0, 0);

        // Zero block, restarts mid-run ignored
        issue(0, 96'h0, 32'h0, 24'hFFFFFF, acc);
        q0.push_back(mk(96'h0, 32'h0, 24'hFFFFFF, 32, 17, acc + 33, 1'b0));
        wait_until(acc + 4);
        blk = 96'hDEAD; nonce = 32'h5; target = 24'h0; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        wait_until(acc + 19);
        start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        wait_until(acc + 45);
        chk("single_valid_drained", q0.size(), 0);

        // Back-to-back with start held high
        ba  = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
        bb2 = 96'hFFEE_DDCC_BBAA_0099_8877_6655;
        t4  = SEARCH ? 24'hFFFFFF : 24'h000000;
        @(negedge clk);
        blk = ba; nonce = 32'hDEAD_BEEF; target = t4; start0 = 1'b1;
        acc = cyc + 1;
        q0.push_back(mk(ba, 32'hDEAD_BEEF, t4, 32, 17, acc + 33, 1'b0));
        q0.push_back(mk(bb2, 32'h0000_0001, t4, 32, 17, acc + 66, 1'b0));
        @(negedge clk);
        blk = bb2; nonce = 32'h0000_0001;
        wait_until(acc + 33);
        start0 = 1'b0;
        wait_until(acc + 75);
        chk("b2b_drained", q0.size(), 0);

        // Mid-range target on a patterned block
        t4 = SEARCH ? 24'hFFFFFF : 24'h800000;
        issue(0, 96'hA5A5_5A5A_0F0F_F0F0_1234_5678, 32'h8000_0001, t4, acc);
        q0.push_back(mk(96'hA5A5_5A5A_0F0F_F0F0_1234_5678, 32'h8000_0001, t4, 32, 17, acc + 33, 1'b0));
        wait_until(acc + 40);

        // 16-round, all K2/OR instance
        t4 = SEARCH ? 24'hFFFFFF : 24'h400000;
        issue(1, 96'hCAFE_BABE_0BAD_F00D_1357_9BDF, 32'h1234_5678, t4, acc);
        q1.push_back(mk(96'hCAFE_BABE_0BAD_F00D_1357_9BDF, 32'h1234_5678, t4, 16, 0, acc + 17, 1'b0));
        wait_until(acc + 25);
        chk("dut16_drained", q1.size(), 0);

        if (SEARCH) begin
            issue(0, ba, 32'hFFFF_FFFE, 24'h0, acc);
            q0.push_back(mk(ba, 32'hFFFF_FFFF, 24'h0, 32, 17, acc + 66, 1'b1));
            wait_until(acc + 75);
            chk("search_exh_drained", q0.size(), 0);
            issue(0, bb2, 32'h0000_0007, 24'hFFFFFF, acc);
            q0.push_back(mk(bb2, 32'h0000_0007, 24'hFFFFFF, 32, 17, acc + 33, 1'b0));
            wait_until(acc + 45);
        end

        repeat (5) @(negedge clk);
        chk("final_q0_empty", q0.size(), 0);
        chk("final_q1_empty", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
